// File: rtl/eth_rx_arbiter.sv
// Frame-granular round-robin arbiter merging two MAC RX byte streams into one ip_parser feed.
// Define ARB_STATS_EN to add saturating per-port frame and abort counters.
module eth_rx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_eof,
  input  logic       s0_err,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_eof,
  input  logic       s1_err,
  output logic       s1_ready,
  output logic [7:0] eth_data_out,
  output logic       eth_byte_valid,
  output logic       eth_eof,
  output logic       eth_err,
  output logic [1:0] grant,
  output logic       timeout
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] frames0,
  output logic [CNT_WIDTH-1:0] frames1,
  output logic [CNT_WIDTH-1:0] aborts
`endif
);

  // state | meaning
  // IDLE  | no owner, pick next port round-robin
  // XFER  | forward granted port's bytes, watchdog armed
  // ABORT | one-cycle eth_err/timeout pulse after a stall
  // DRAIN | swallow the rest of the aborted frame
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [1:0]      state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      data_q, data_d;
  logic            vld_q, vld_d, eof_q, eof_d, err_q, err_d, to_q, to_d;

  logic       active, sel, xfer, in_eof, in_err, frame_end;
  logic [7:0] in_data;

  assign active    = (state_q == S_XFER) || (state_q == S_DRAIN);
  assign s0_ready  = active && grant_q[0];
  assign s1_ready  = active && grant_q[1];
  assign sel       = grant_q[1];
  assign xfer      = (s0_valid && s0_ready) || (s1_valid && s1_ready);
  assign in_data   = sel ? s1_data : s0_data;
  assign in_eof    = sel ? s1_eof  : s0_eof;
  assign in_err    = sel ? s1_err  : s0_err;
  assign frame_end = xfer && (in_eof || in_err);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    eof_d   = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (s0_valid && (!s1_valid || last_q)) begin
          grant_d = 2'b01;
          last_d  = 1'b0;
          state_d = S_XFER;
        end else if (s1_valid) begin
          grant_d = 2'b10;
          last_d  = 1'b1;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (xfer) begin
          data_d = in_data;
          vld_d  = 1'b1;
          eof_d  = in_eof;
          err_d  = in_err;
          wd_d   = '0;
          if (in_eof || in_err) begin
            state_d = S_IDLE;
            grant_d = 2'b00;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          // wd_q counts stall cycles already spent; the limit-th stall cycle triggers abort
          if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_ABORT;
            err_d   = 1'b1;
            to_d    = 1'b1;
            wd_d    = '0;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      S_ABORT: state_d = S_DRAIN;
      S_DRAIN: begin
        if (frame_end) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      wd_q    <= '0;
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign eth_data_out   = data_q;
  assign eth_byte_valid = vld_q;
  assign eth_eof        = eof_q;
  assign eth_err        = err_q;
  assign grant          = grant_q;
  assign timeout        = to_q;

`ifdef ARB_STATS_EN
  logic [CNT_WIDTH-1:0] frames0_q, frames1_q, aborts_q;
  logic                 done_xfer;

  // only frames that completed normally count; drained frames show up in aborts
  assign done_xfer = (state_q == S_XFER) && frame_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames0_q <= '0;
      frames1_q <= '0;
      aborts_q  <= '0;
    end else begin
      if (done_xfer && !sel && (frames0_q != '1)) frames0_q <= frames0_q + 1'b1;
      if (done_xfer && sel && (frames1_q != '1))  frames1_q <= frames1_q + 1'b1;
      if (to_d && (aborts_q != '1))               aborts_q  <= aborts_q + 1'b1;
    end
  end

  assign frames0 = frames0_q;
  assign frames1 = frames1_q;
  assign aborts  = aborts_q;
`endif

endmodule

// File: tb/tb_eth_rx_arbiter.sv
// Directed bench for eth_rx_arbiter: single-port stream, ties, error end, watchdog abort, async reset.
module tb_eth_rx_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] s0_data, s1_data;
  logic       s0_valid, s0_eof, s0_err, s0_ready;
  logic       s1_valid, s1_eof, s1_err, s1_ready;
  logic [7:0] eth_data_out;
  logic       eth_byte_valid, eth_eof, eth_err, timeout;
  logic [1:0] grant;
`ifdef ARB_STATS_EN
  logic [3:0] frames0, frames1, aborts;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int both_ready = 0;

  typedef struct {logic [7:0] d; logic v; logic e; logic r; logic t; int cyc;} out_t;
  typedef struct {int port; logic [7:0] d; logic [1:0] g; int cyc;} xf_t;
  out_t outq[$];
  xf_t  xq[$];

  eth_rx_arbiter #(.TIMEOUT_CYCLES(64), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_eof(s0_eof), .s0_err(s0_err), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_eof(s1_eof), .s1_err(s1_err), .s1_ready(s1_ready),
    .eth_data_out(eth_data_out), .eth_byte_valid(eth_byte_valid), .eth_eof(eth_eof),
    .eth_err(eth_err), .grant(grant), .timeout(timeout)
`ifdef ARB_STATS_EN
    , .frames0(frames0), .frames1(frames1), .aborts(aborts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (s0_valid && s0_ready) xq.push_back('{0, s0_data, grant, cyc});
      if (s1_valid && s1_ready) xq.push_back('{1, s1_data, grant, cyc});
      if (s0_ready && s1_ready) both_ready++;
      if (eth_byte_valid || eth_eof || eth_err || timeout)
        outq.push_back('{eth_data_out, eth_byte_valid, eth_eof, eth_err, timeout, cyc});
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic set_src(input int port, input logic v, input logic [7:0] d, input logic e, input logic r);
    if (port == 0) begin
      s0_valid = v; s0_data = d; s0_eof = e; s0_err = r;
    end else begin
      s1_valid = v; s1_data = d; s1_eof = e; s1_err = r;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the last byte.
  task automatic drive_frame(input int port, input int n, input int gap, input logic [7:0] base,
                             input int err_at, input bit eof_last, input int stall_after,
                             input int stall_len, input int start_delay);
    bit accepted;
    int w;
    repeat (start_delay) begin @(posedge clk); #1; end
    for (int i = 0; i < n; i++) begin
      w = gap + ((i == stall_after) ? stall_len : 0);
      set_src(port, 1'b0, 8'h00, 1'b0, 1'b0);
      repeat (w) begin @(posedge clk); #1; end
      set_src(port, 1'b1, 8'(base + i), eof_last && (i == n - 1), (i + 1) == err_at);
      accepted = 0;
      for (int b = 0; b < 2000 && !accepted; b++) begin
        @(negedge clk);
        if ((port == 0) ? s0_ready : s1_ready) accepted = 1;
        @(posedge clk); #1;
      end
      checks++;
      if (!accepted) begin
        errors++;
        $display("FAIL handshake port %0d byte %0d never accepted", port, i);
      end
    end
    set_src(port, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    outq.delete();
    xq.delete();
    both_ready = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (eth_byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", eth_byte_valid); end
    checks++; if (eth_eof !== 1'b0) begin errors++; $display("FAIL reset_eof got %b want 0", eth_eof); end
    checks++; if (eth_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", eth_err); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
    checks++; if (eth_data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", eth_data_out); end
    checks++; if ({s0_ready, s1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {s0_ready, s1_ready}); end
`ifdef ARB_STATS_EN
    checks++; if ({frames0, frames1, aborts} !== 12'h000) begin errors++; $display("FAIL reset_stats got %h want 000", {frames0, frames1, aborts}); end
`endif
    apply_reset();
  endtask

  task automatic test_single_port();
    apply_reset();
    drive_frame(0, 55, 3, 8'h10, 0, 1'b1, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (outq.size() != 55 || xq.size() != 55) begin
      errors++; $display("FAIL single_count got out=%0d xfer=%0d want 55", outq.size(), xq.size());
    end
    for (int i = 0; i < 55 && i < outq.size() && i < xq.size(); i++) begin
      checks++;
      if (outq[i].d !== 8'(8'h10 + i) || outq[i].v !== 1'b1 || outq[i].r !== 1'b0) begin
        errors++; $display("FAIL single_data byte %0d got %h v%b r%b want %h v1 r0", i, outq[i].d, outq[i].v, outq[i].r, 8'(8'h10 + i));
      end
      checks++;
      if (outq[i].e !== (i == 54)) begin
        errors++; $display("FAIL single_eof byte %0d got %b want %b", i, outq[i].e, (i == 54));
      end
      checks++;
      if (outq[i].cyc != xq[i].cyc + 1) begin
        errors++; $display("FAIL single_latency byte %0d got %0d want 1", i, outq[i].cyc - xq[i].cyc);
      end
      checks++;
      if (xq[i].g !== 2'b01 || xq[i].port != 0) begin
        errors++; $display("FAIL single_grant byte %0d got %b want 01", i, xq[i].g);
      end
    end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_grant_idle got %b want 00", grant); end
  endtask

  task automatic test_tie();
    logic [7:0] exp_d;
    int exp_p;
    apply_reset();
    fork
      begin
        drive_frame(0, 10, 0, 8'h40, 0, 1'b1, 0, 0, 0);
        drive_frame(0, 10, 0, 8'h50, 0, 1'b1, 0, 0, 0);
      end
      drive_frame(1, 10, 0, 8'h80, 0, 1'b1, 0, 0, 0);
    join
    repeat (3) @(negedge clk);
    checks++;
    if (outq.size() != 30 || xq.size() != 30) begin
      errors++; $display("FAIL tie_count got out=%0d xfer=%0d want 30", outq.size(), xq.size());
    end
    for (int i = 0; i < 30 && i < outq.size() && i < xq.size(); i++) begin
      exp_d = (i < 10) ? 8'(8'h40 + i) : (i < 20) ? 8'(8'h80 + i - 10) : 8'(8'h50 + i - 20);
      exp_p = (i >= 10 && i < 20) ? 1 : 0;
      checks++;
      if (outq[i].d !== exp_d || outq[i].e !== (i % 10 == 9) || xq[i].port != exp_p) begin
        errors++; $display("FAIL tie_order idx %0d got %h eof%b port%0d want %h eof%b port%0d",
                           i, outq[i].d, outq[i].e, xq[i].port, exp_d, (i % 10 == 9), exp_p);
      end
    end
    if (outq.size() == 30) begin
      checks++;
      if (outq[10].cyc - outq[9].cyc < 2 || outq[20].cyc - outq[19].cyc < 2) begin
        errors++; $display("FAIL tie_gap got %0d/%0d want >=2", outq[10].cyc - outq[9].cyc, outq[20].cyc - outq[19].cyc);
      end
    end
    checks++; if (both_ready != 0) begin errors++; $display("FAIL tie_both_ready got %0d want 0", both_ready); end
  endtask

  task automatic test_err_end();
    logic [7:0] exp_d;
    apply_reset();
    fork
      drive_frame(1, 20, 0, 8'hA0, 20, 1'b0, 0, 0, 0);
      drive_frame(0, 3, 0, 8'h30, 3, 1'b1, 0, 0, 5);
    join
    repeat (3) @(negedge clk);
    checks++;
    if (outq.size() != 23) begin errors++; $display("FAIL err_count got %0d want 23", outq.size()); end
    for (int i = 0; i < 23 && i < outq.size(); i++) begin
      exp_d = (i < 20) ? 8'(8'hA0 + i) : 8'(8'h30 + i - 20);
      checks++;
      if (outq[i].d !== exp_d || outq[i].v !== 1'b1 || outq[i].r !== (i == 19 || i == 22) ||
          outq[i].e !== (i == 22)) begin
        errors++; $display("FAIL err_byte idx %0d got %h v%b e%b r%b want %h v1 e%b r%b",
                           i, outq[i].d, outq[i].v, outq[i].e, outq[i].r, exp_d, (i == 22), (i == 19 || i == 22));
      end
    end
    if (outq.size() == 23) begin
      checks++;
      if (outq[20].cyc - outq[19].cyc < 2) begin
        errors++; $display("FAIL err_gap got %0d want >=2", outq[20].cyc - outq[19].cyc);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    drive_frame(0, 20, 0, 8'h60, 0, 1'b1, 8, 100, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (xq.size() != 20) begin errors++; $display("FAIL to_drained got %0d want 20", xq.size()); end
    checks++;
    if (outq.size() != 9) begin errors++; $display("FAIL to_out_count got %0d want 9", outq.size()); end
    for (int i = 0; i < 8 && i < outq.size(); i++) begin
      checks++;
      if (outq[i].d !== 8'(8'h60 + i) || outq[i].v !== 1'b1 || outq[i].r !== 1'b0) begin
        errors++; $display("FAIL to_byte idx %0d got %h v%b want %h v1", i, outq[i].d, outq[i].v, 8'(8'h60 + i));
      end
    end
    if (outq.size() >= 9 && xq.size() >= 8) begin
      checks++;
      if (outq[8].v !== 1'b0 || outq[8].r !== 1'b1 || outq[8].t !== 1'b1 || outq[8].e !== 1'b0) begin
        errors++; $display("FAIL to_abort got v%b r%b t%b e%b want v0 r1 t1 e0", outq[8].v, outq[8].r, outq[8].t, outq[8].e);
      end
      checks++;
      if (outq[8].cyc - xq[7].cyc != 65) begin
        errors++; $display("FAIL to_stall_len got %0d want 65", outq[8].cyc - xq[7].cyc);
      end
    end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_grant_idle got %b want 00", grant); end
`ifdef ARB_STATS_EN
    checks++; if (aborts !== 4'd1 || frames0 !== 4'd0) begin errors++; $display("FAIL to_stats got aborts=%0d frames0=%0d want 1/0", aborts, frames0); end
`endif
  endtask

  task automatic test_reset_midframe();
    int n;
    bit hit;
    apply_reset();
    n = 0;
    hit = 0;
    set_src(0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int b = 0; b < 500 && !hit; b++) begin
      @(negedge clk);
      if (s0_ready) begin
        n++;
        if (n == 30) hit = 1;
      end
      if (!hit) begin @(posedge clk); #1; s0_data = 8'(n); end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_reach got %0d want 30", n); end
    checks++;
    if (eth_byte_valid !== 1'b1 || eth_data_out !== 8'd28) begin
      errors++; $display("FAIL rstmid_pre got v%b %h want v1 1c", eth_byte_valid, eth_data_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({eth_byte_valid, eth_eof, eth_err, timeout} !== 4'b0000 || eth_data_out !== 8'h00 ||
        grant !== 2'b00 || {s0_ready, s1_ready} !== 2'b00) begin
      errors++; $display("FAIL rstmid_async got v%b e%b r%b t%b d%h g%b rdy%b%b want all 0",
                         eth_byte_valid, eth_eof, eth_err, timeout, eth_data_out, grant, s0_ready, s1_ready);
    end
    set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    set_src(0, 1'b1, 8'hEE, 1'b1, 1'b0);
    set_src(1, 1'b1, 8'hDD, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL rstmid_tie got %b want 01", grant); end
    set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats_sat();
    apply_reset();
    for (int f = 0; f < 17; f++) drive_frame(0, 1, 0, 8'(f), 0, 1'b1, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (frames0 !== 4'hF || frames1 !== 4'h0 || aborts !== 4'h0) begin
      errors++; $display("FAIL stats_sat got f0=%0d f1=%0d ab=%0d want 15/0/0", frames0, frames1, aborts);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    set_src(0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0, 1'b0);
    test_reset();
    test_single_port();
    test_tie();
    test_err_end();
    test_timeout();
    test_reset_midframe();
`ifdef ARB_STATS_EN
    test_stats_sat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_arbiter.md
Name: eth_rx_arbiter

Overview:
- Frame-granular round-robin arbiter between two Ethernet RX byte streams (MAC FIFO outputs, port 0 and port 1) that feeds the single shared ip_parser instance.
- Whole frames are never interleaved.
- A stall watchdog aborts a frame whose source stops mid-frame, signals eth_err to the parser, and discards the remainder of that frame.

Parameters:
TIMEOUT_CYCLES, 64, idle cycles allowed between accepted bytes of a granted frame before abort; 0 disables the watchdog
CNT_WIDTH, 16, width of statistics counters (optional feature only)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
s0_data  input  8  port 0 byte
s0_valid  input  1  port 0 byte available
s0_eof  input  1  port 0 last byte of frame, qualified by s0_valid
s0_err  input  1  port 0 frame error (CRC/MAC), qualified by s0_valid
s0_ready  output  1  port 0 byte accepted when s0_valid && s0_ready
s1_data / s1_valid / s1_eof / s1_err / s1_ready  same widths/directions, port 1
eth_data_out  output  8  byte to ip_parser eth_data_in
eth_byte_valid  output  1  byte strobe to ip_parser
eth_eof  output  1  end of frame to ip_parser, coincident with last eth_byte_valid
eth_err  output  1  frame error/abort to ip_parser
grant  output  2  one-hot current owner; 00 when idle
timeout  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; last_owner=1, so port 0 wins the first tie; watchdog counter 0. Reset mid-frame discards the frame with no eth_eof/eth_err emitted.
- States: IDLE, XFER, ABORT, DRAIN.
- IDLE:
  - sN_ready=0.
  - If exactly one sN_valid, grant it.
  - If both valid, grant the port != last_owner.
  - Next cycle: state XFER, grant one-hot, last_owner updated.
- XFER:
  - Granted port's ready=1; other port's ready=0.
  - On transfer, next cycle drives eth_data_out=data, eth_byte_valid=1, eth_eof=eof, eth_err=err. Latency is exactly 1 cycle, registered.
  - Transfer with eof=1 or err=1: frame ends, next state IDLE. At least one IDLE cycle separates frames.
  - eof and err set together: forward both, end frame.
  - Watchdog counter clears on each transfer and increments on each XFER cycle without a transfer. When it reaches TIMEOUT_CYCLES (nonzero), next state ABORT.
- ABORT (1 cycle):
  - eth_err=1, eth_byte_valid=0, timeout=1, ready=0.
  - Next state DRAIN.
- DRAIN:
  - Granted port's ready=1; accepted bytes are discarded, so eth_* stay 0.
  - Exits to IDLE on a transfer with eof or err.
  - No watchdog in DRAIN.
- Outputs eth_byte_valid, eth_eof, eth_err, timeout are single-cycle pulses, 0 otherwise. eth_data_out holds its last value when not valid.
- Non-granted port is never acknowledged; its valid may stay high indefinitely.
- grant is held through XFER/ABORT/DRAIN and returns to 00 in IDLE.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds outputs:
  - frames0, frames1 (CNT_WIDTH): frames completed per port, counting eof or err transfers in XFER.
  - aborts (CNT_WIDTH): count of ABORT entries.
  - All three saturate at all-ones and clear on rst.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Port 0 only, 55-byte frame at one byte per 4 cycles (s0_eof on byte 55) -> 55 eth_byte_valid pulses, data identical and in order, each 1 cycle after its transfer; eth_eof on byte 55 only; grant=01 during frame, then 00.
- Both ports valid in the same cycle after reset, 10-byte frames each -> port 0 frame forwarded completely, then at least 1 idle cycle, then port 1 frame; no interleaving; a repeat tie grants port 1 first.
- Port 1 frame with s1_err on byte 20 of 20 -> eth_err and eth_byte_valid high on the same cycle for byte 20; next state IDLE; port 0 served afterwards.
- TIMEOUT_CYCLES=64, port 0 stalls after byte 8 -> exactly 64 stall cycles, then timeout=1 and eth_err=1 for one cycle; remaining bytes through eof drained with no eth_byte_valid; with ARB_STATS_EN, aborts=1.
- rst asserted on byte 30 of a port 0 frame -> all outputs 0 immediately (async); after release, the next tie grants port 0.
- ARB_STATS_EN with CNT_WIDTH=4, 17 port 0 frames -> frames0 saturates at 15.
